// File: rtl/audio_tone_gen.sv
// audio_tone_gen: sample-rate tone generator (phase accumulator, waveform shaper,
// attack/release envelope) feeding the PWM serializer's 10-bit duty input.
`default_nettype none

module audio_tone_gen #(
  parameter int SYS_FREQ_MHZ   = 100,
  parameter int SAMPLE_RATE_HZ = 48000,
  parameter int PHASE_BITS     = 24,
  parameter int ATTACK_STEP    = 4,
  parameter int RELEASE_STEP   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [PHASE_BITS-1:0] cmd_inc,
  input  logic [1:0]            cmd_wave,
  input  logic                  cmd_gate,
  output logic [9:0]            duty_cycle,
  output logic                  sample_tick,
  output logic                  active
);

  localparam int DIV = SYS_FREQ_MHZ * 1_000_000 / SAMPLE_RATE_HZ;
  localparam int CW  = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  logic [CW-1:0]         cnt;
  logic                  tick, tick_d;
  logic                  pend_v, pend_gate, gate;
  logic [PHASE_BITS-1:0] pend_inc, inc, phase, phase_n, inc_n;
  logic [1:0]            pend_wave, wave;
  logic [7:0]            amp, amp_n;
  state_t                state, state_n;
  logic                  gate_n, load;
  logic [8:0]            amp_sum;

  assign tick      = (cnt == CW'(DIV - 1));
  assign cmd_ready = ~pend_v;
  assign load      = tick & pend_v;
  assign inc_n     = load ? pend_inc : inc;
  assign gate_n    = load ? pend_gate : gate;
  assign amp_sum   = {1'b0, amp} + 9'(ATTACK_STEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      tick_d    <= 1'b0;
      pend_v    <= 1'b0;
      pend_inc  <= '0;
      pend_wave <= 2'd0;
      pend_gate <= 1'b0;
      inc       <= '0;
      wave      <= 2'd0;
      gate      <= 1'b0;
      phase     <= '0;
      amp       <= 8'd0;
      state     <= IDLE;
      active    <= 1'b0;
    end else begin
      cnt    <= tick ? '0 : cnt + 1'b1;
      tick_d <= tick;
      if (load) begin
        inc    <= pend_inc;
        wave   <= pend_wave;
        gate   <= pend_gate;
        pend_v <= 1'b0;
      end
      // ready is low while pending, so accept and load never coincide
      if (cmd_valid && !pend_v) begin
        pend_inc  <= cmd_inc;
        pend_wave <= cmd_wave;
        pend_gate <= cmd_gate;
        pend_v    <= 1'b1;
      end
      phase  <= phase_n;
      amp    <= amp_n;
      state  <= state_n;
      active <= (state_n != IDLE);
    end
  end

  // Envelope sees the gate as it stands after this tick's command load
  always_comb begin
    state_n = state;
    amp_n   = amp;
    phase_n = phase;
    if (tick) begin
      if (gate_n) begin
        if (state != SUSTAIN) begin
          amp_n   = amp_sum[8] ? 8'd255 : amp_sum[7:0];
          state_n = (amp_n == 8'd255) ? SUSTAIN : ATTACK;
        end
      end else if (state != IDLE) begin
        amp_n   = (amp > 8'(RELEASE_STEP)) ? amp - 8'(RELEASE_STEP) : 8'd0;
        state_n = (amp_n == 8'd0) ? IDLE : RELEASE;
      end
      phase_n = (state_n == IDLE) ? '0 : phase + inc_n;
    end
  end

  logic [9:0]         p, raw;
  logic signed [10:0] s;
  logic signed [19:0] prod;
  logic [9:0]         duty_n;

  assign p = phase[PHASE_BITS-1 -: 10];

  always_comb begin
    raw = 10'd512;
    case (wave)
      2'd0:    raw = p[9] ? 10'd1023 : 10'd0;
      2'd1:    raw = p;
      2'd2:    raw = p[9] ? 10'd1023 - {p[8:0], 1'b0} : {p[8:0], 1'b0};
      default: raw = 10'd512;
    endcase
    s      = $signed({1'b0, raw}) - 11'sd512;
    prod   = s * $signed({1'b0, amp});
    // Scaled value is always within -512..511, so mod-1024 offset is exact
    duty_n = 10'(prod >>> 8) + 10'd512;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_cycle  <= 10'd512;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= tick_d;
      if (tick_d) duty_cycle <= duty_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_audio_tone_gen.sv
// tb_audio_tone_gen: scoreboard bench for audio_tone_gen with DIV=10, 12-bit phase.
`default_nettype none

module tb_audio_tone_gen;

  localparam int DIV = 10;
  localparam int PB  = 12;
  localparam int AS  = 64;
  localparam int RS  = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [PB-1:0] cmd_inc = '0;
  logic [1:0]    cmd_wave = 2'd0;
  logic          cmd_gate = 1'b0;
  logic [9:0]    duty_cycle;
  logic          sample_tick;
  logic          active;

  audio_tone_gen #(
    .SYS_FREQ_MHZ(1), .SAMPLE_RATE_HZ(100000), .PHASE_BITS(PB),
    .ATTACK_STEP(AS), .RELEASE_STEP(RS)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_inc(cmd_inc), .cmd_wave(cmd_wave), .cmd_gate(cmd_gate),
    .duty_cycle(duty_cycle), .sample_tick(sample_tick), .active(active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int q[$];

  // Reference model state (states: 0 idle, 1 attack, 2 sustain, 3 release)
  int m_cnt = 0, m_pend = 0, m_pinc = 0, m_pwave = 0, m_pgate = 0;
  int m_inc = 0, m_wave = 0, m_gate = 0, m_amp = 0, m_phase = 0, m_st = 0;
  int m_stick = 0, m_stick_next = 0;

  function automatic int ref_duty(int ph, int wv, int a);
    int pp, raw;
    pp = ph >> (PB - 10);
    case (wv)
      0:       raw = (pp >= 512) ? 1023 : 0;
      1:       raw = pp;
      2:       raw = (pp >= 512) ? 1023 - 2 * (pp - 512) : 2 * pp;
      default: raw = 512;
    endcase
    return 512 + (((raw - 512) * a) >>> 8);
  endfunction

  task automatic check(string tag, int got, int want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  always @(posedge clk or posedge reset) begin : model
    int tk, acc;
    if (reset) begin
      m_cnt = 0; m_pend = 0; m_pinc = 0; m_pwave = 0; m_pgate = 0;
      m_inc = 0; m_wave = 0; m_gate = 0; m_amp = 0; m_phase = 0; m_st = 0;
      m_stick = 0; m_stick_next = 0;
      q.delete();
    end else begin
      tk  = (m_cnt == DIV - 1) ? 1 : 0;
      acc = (cmd_valid && m_pend == 0) ? 1 : 0;
      if (m_stick_next != 0) q.push_back(ref_duty(m_phase, m_wave, m_amp));
      m_stick      = m_stick_next;
      m_stick_next = tk;
      if (tk != 0) begin
        if (m_pend != 0) begin
          m_inc = m_pinc; m_wave = m_pwave; m_gate = m_pgate; m_pend = 0;
        end
        if (m_gate != 0) begin
          if (m_st != 2) begin
            m_amp = (m_amp + AS > 255) ? 255 : m_amp + AS;
            m_st  = (m_amp == 255) ? 2 : 1;
          end
        end else if (m_st != 0) begin
          m_amp = (m_amp > RS) ? m_amp - RS : 0;
          m_st  = (m_amp == 0) ? 0 : 3;
        end
        m_phase = (m_st == 0) ? 0 : (m_phase + m_inc) % (1 << PB);
      end
      if (acc != 0) begin
        m_pinc = int'(cmd_inc); m_pwave = int'(cmd_wave); m_pgate = int'(cmd_gate);
        m_pend = 1;
      end
      m_cnt = (m_cnt + 1) % DIV;
    end
  end

  int cyc = 0;
  int last_tick = -1;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      last_tick = -1;
    end else begin
      check("cmd_ready", int'(cmd_ready), (m_pend == 0) ? 1 : 0);
      check("active", int'(active), (m_st != 0) ? 1 : 0);
      check("sample_tick", int'(sample_tick), m_stick);
      if (sample_tick) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $error("FAIL scoreboard: observed sample with duty %0d, expected none queued", duty_cycle);
        end else begin
          check("duty_cycle", int'(duty_cycle), q.pop_front());
        end
        if (last_tick >= 0) check("tick_period", cyc - last_tick, DIV);
        last_tick = cyc;
      end
    end
  end

  task automatic send(int inc, int wv, int g);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_inc = PB'(inc); cmd_wave = 2'(wv); cmd_gate = g[0];
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        return;
      end
    end
    n_cmp++; n_bad++;
    $error("FAIL send_timeout: observed no cmd_ready, expected acceptance");
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ticks(int n);
    int seen = 0;
    for (int i = 0; i < n * DIV + 20 && seen < n; i++) begin
      @(negedge clk);
      if (sample_tick) seen++;
    end
    if (seen < n) begin
      n_cmp++; n_bad++;
      $error("FAIL tick_timeout: observed %0d ticks expected %0d", seen, n);
    end
  endtask

  task automatic wait_model(int st);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_st == st && m_pend == 0) return;
    end
    n_cmp++; n_bad++;
    $error("FAIL state_timeout: observed state %0d expected %0d", m_st, st);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_duty"}, int'(duty_cycle), 512);
    check({tag, "_tick"}, int'(sample_tick), 0);
    check({tag, "_active"}, int'(active), 0);
    check({tag, "_ready"}, int'(cmd_ready), 1);
  endtask

  initial begin
    int nt;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    // First sample_tick lands on the 11th cycle after release, then every 10
    nt = 0;
    repeat (55) begin
      @(negedge clk);
      if (sample_tick) nt++;
      check("idle_duty", int'(duty_cycle), 512);
    end
    check("idle_tick_count", nt, 5);

    // Note on: saw, amp ramps 64,128,192,255 then sustains
    send(256, 1, 1);
    wait_ticks(7);

    // Back-pressure: second command waits for the first to load
    send(512, 2, 1);
    @(negedge clk);
    check("bp_ready", int'(cmd_ready), 0);
    send(256, 0, 1);
    wait_ticks(4);

    // Release from 255, retrigger from 127, then full release to idle
    send(256, 0, 0);
    wait_model(3);
    send(256, 0, 1);
    wait_model(1);
    wait_ticks(3);
    send(256, 0, 0);
    wait_model(0);
    wait_ticks(2);
    check("idle_end_duty", int'(duty_cycle), 512);
    check("idle_end_active", int'(active), 0);

    // Phase wrap with inc=0xFFF on square and triangle, then triangle peak
    send(12'hFFF, 0, 1);
    wait_ticks(8);
    send(12'hFFF, 2, 1);
    wait_ticks(6);
    send(12'h200, 2, 1);
    wait_ticks(8);

    // Reset during release with a command pending
    send(256, 0, 0);
    wait_model(3);
    send(256, 1, 1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("post_reset_active", int'(active), 0);
    check("post_reset_duty", int'(duty_cycle), 512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
